// File: rtl/matmul_pkg.sv
// matmul_pkg: register map, CONTROL fields and loader states shared by the matmul APB loader
package matmul_pkg;
  localparam logic [4:0] REG_CONTROL   = 5'h00;
  localparam logic [4:0] REG_OPERAND_A = 5'h04;
  localparam logic [4:0] REG_OPERAND_B = 5'h08;
  localparam logic [4:0] REG_FLAGS     = 5'h0C;
  localparam logic [4:0] REG_SP        = 5'h10;
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_SP_LSB    = 2;
  localparam int CTRL_N_LSB     = 8;
  localparam int CTRL_K_LSB     = 10;
  localparam int CTRL_M_LSB     = 12;
  localparam int CTRL_WIDTH     = 14;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GATHER_A,
    ST_WR_A,
    ST_GATHER_B,
    ST_WR_B,
    ST_WR_CTRL,
    ST_POLL,
    ST_DONE
  } loader_state_e;
  function automatic logic [CTRL_WIDTH-1:0] control_word(input logic [1:0] n, k, m, sp);
    return (CTRL_WIDTH'(m) << CTRL_M_LSB) | (CTRL_WIDTH'(k) << CTRL_K_LSB) |
           (CTRL_WIDTH'(n) << CTRL_N_LSB) | (CTRL_WIDTH'(sp) << CTRL_SP_LSB) |
           (CTRL_WIDTH'(1) << CTRL_START_BIT);
  endfunction
endpackage

// File: rtl/apb_master_port.sv
// apb_master_port: single APB transfer engine with setup/access phases and an idle cycle after each transfer
module apb_master_port #(
  parameter int ADDR_WIDTH = 16,
  parameter int BUS_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [BUS_WIDTH-1:0]  wdata,
  output logic                  ack,
  output logic [BUS_WIDTH-1:0]  rdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [BUS_WIDTH-1:0]  pwdata,
  input  logic                  pready,
  input  logic [BUS_WIDTH-1:0]  prdata
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else if (!psel) begin
      psel <= req;
      if (req) begin
        pwrite <= write;
        paddr  <= addr;
        pwdata <= wdata;
      end
    end else if (!penable) begin
      penable <= 1'b1;
    end else if (pready) begin
      psel    <= 1'b0;
      penable <= 1'b0;
    end
  end
  assign ack   = psel && penable && pready;
  assign rdata = prdata;
endmodule

// File: rtl/matmul_apb_loader.sv
// matmul_apb_loader: packs A rows and B columns into APB writes, starts the matmul slave and polls for completion
module matmul_apb_loader
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int POLL_LIMIT = 1024
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              cmd_valid_i,
  output logic                              cmd_ready_o,
  input  logic [1:0]                        cmd_n_i,
  input  logic [1:0]                        cmd_k_i,
  input  logic [1:0]                        cmd_m_i,
  input  logic [1:0]                        cmd_sp_i,
  input  logic                              elem_valid_i,
  output logic                              elem_ready_o,
  input  logic [DATA_WIDTH-1:0]             elem_data_i,
  output logic                              psel_o,
  output logic                              penable_o,
  output logic                              pwrite_o,
  output logic [ADDR_WIDTH-1:0]             paddr_o,
  output logic [BUS_WIDTH-1:0]              pwdata_o,
  output logic [BUS_WIDTH/DATA_WIDTH-1:0]   pstrb_o,
  input  logic                              pready_i,
  input  logic [BUS_WIDTH-1:0]              prdata_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              timeout_o
);
  localparam int PW = $clog2(POLL_LIMIT + 1);
  loader_state_e         state;
  logic [1:0]            n, k, m, sp, idx, e;
  logic [BUS_WIDTH-1:0]  pack, wdata, rdata;
  logic [ADDR_WIDTH-1:0] addr;
  logic [PW-1:0]         poll_cnt;
  logic                  req, write, ack, start_set, timed_out;
  always_comb begin
    req       = state inside {ST_WR_A, ST_WR_B, ST_WR_CTRL, ST_POLL};
    write     = state != ST_POLL;
    addr      = state == ST_WR_A ? ADDR_WIDTH'({idx, REG_OPERAND_A}) :
                state == ST_WR_B ? ADDR_WIDTH'({idx, REG_OPERAND_B}) : ADDR_WIDTH'(REG_CONTROL);
    wdata     = state == ST_WR_CTRL ? BUS_WIDTH'(control_word(n, k, m, sp)) :
                state == ST_POLL ? '0 : pack;
    start_set = |(rdata & BUS_WIDTH'(1 << CTRL_START_BIT));
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      n         <= '0;
      k         <= '0;
      m         <= '0;
      sp        <= '0;
      idx       <= '0;
      e         <= '0;
      pack      <= '0;
      poll_cnt  <= '0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (cmd_valid_i) begin
          n         <= cmd_n_i;
          k         <= cmd_k_i;
          m         <= cmd_m_i;
          sp        <= cmd_sp_i;
          idx       <= '0;
          e         <= '0;
          pack      <= '0;
          poll_cnt  <= '0;
          timed_out <= 1'b0;
          state     <= ST_GATHER_A;
        end
        ST_GATHER_A, ST_GATHER_B: if (elem_valid_i) begin
          pack[e*DATA_WIDTH +: DATA_WIDTH] <= elem_data_i;
          e <= e == k ? 2'd0 : e + 2'd1;
          if (e == k) state <= state == ST_GATHER_A ? ST_WR_A : ST_WR_B;
        end
        ST_WR_A: if (ack) begin
          pack  <= '0;
          idx   <= idx == n ? 2'd0 : idx + 2'd1;
          state <= idx == n ? ST_GATHER_B : ST_GATHER_A;
        end
        ST_WR_B: if (ack) begin
          pack  <= '0;
          idx   <= idx == m ? 2'd0 : idx + 2'd1;
          state <= idx == m ? ST_WR_CTRL : ST_GATHER_B;
        end
        ST_WR_CTRL: if (ack) state <= ST_POLL;
        ST_POLL: if (ack) begin
          poll_cnt <= poll_cnt + 1'b1;
          if (!start_set) state <= ST_DONE;
          else if (poll_cnt == PW'(POLL_LIMIT - 1)) begin
            timed_out <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
      endcase
    end
  end
  apb_master_port #(.ADDR_WIDTH(ADDR_WIDTH), .BUS_WIDTH(BUS_WIDTH)) u_port (
    .clk(clk_i),
    .rst(rst_i),
    .req(req),
    .write(write),
    .addr(addr),
    .wdata(wdata),
    .ack(ack),
    .rdata(rdata),
    .psel(psel_o),
    .penable(penable_o),
    .pwrite(pwrite_o),
    .paddr(paddr_o),
    .pwdata(pwdata_o),
    .pready(pready_i),
    .prdata(prdata_i)
  );
  assign cmd_ready_o  = state == ST_IDLE;
  assign elem_ready_o = state == ST_GATHER_A || state == ST_GATHER_B;
  assign busy_o       = state != ST_IDLE;
  assign done_o       = state == ST_DONE;
  assign timeout_o    = state == ST_DONE && timed_out;
  assign pstrb_o      = {(BUS_WIDTH/DATA_WIDTH){psel_o}};
endmodule

// File: tb/tb_matmul_apb_loader.sv
// tb_matmul_apb_loader: directed jobs against an APB slave model with wait states and poll control
module tb_matmul_apb_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_n = '0, cmd_k = '0, cmd_m = '0, cmd_sp = '0;
  logic        elem_valid = 1'b0;
  logic [7:0]  elem_data = '0;
  logic        pready = 1'b0;
  logic [31:0] prdata = '0;
  logic        cmd_ready, elem_ready, psel, penable, pwrite, busy, done, timeout;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  int checks = 0, failures = 0;
  int done_cnt = 0, n_reads = 0, proto_errs = 0, start_reads = 0, wait_max = 0, wait_left = 0;
  logic last_to = 1'b0, never_clear = 1'b0, hold_ready = 1'b0, in_xfer = 1'b0, expect_idle = 1'b0;
  logic [15:0] hold_addr = '0, s_addr;
  logic [31:0] s_data;
  logic        s_write;
  logic [15:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  elems[64];
  logic [15:0] t1_addr[5] = '{16'h0004, 16'h0024, 16'h0008, 16'h0028, 16'h0000};
  logic [31:0] t1_data[5] = '{32'h0201, 32'h0403, 32'h0705, 32'h0806, 32'h1501};

  matmul_apb_loader #(.DATA_WIDTH(8), .BUS_WIDTH(32), .ADDR_WIDTH(16), .POLL_LIMIT(8)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_n_i(cmd_n), .cmd_k_i(cmd_k), .cmd_m_i(cmd_m), .cmd_sp_i(cmd_sp),
    .elem_valid_i(elem_valid), .elem_ready_o(elem_ready), .elem_data_i(elem_data),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
    .pwdata_o(pwdata), .pstrb_o(pstrb), .pready_i(pready), .prdata_i(prdata),
    .busy_o(busy), .done_o(done), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // slave model and protocol monitor, evaluated mid-cycle so every value is settled
  always @(negedge clk) begin
    if (rst) begin
      pready = 1'b0;
      in_xfer = 1'b0;
      expect_idle = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        last_to = timeout;
      end
      if (penable && !psel) proto_errs++;
      if (expect_idle && psel) proto_errs++;
      expect_idle = 1'b0;
      if (psel && !penable) begin
        if (in_xfer) proto_errs++;
        s_addr = paddr;
        s_data = pwdata;
        s_write = pwrite;
        in_xfer = 1'b1;
        wait_left = $urandom_range(0, wait_max);
        pready = 1'b0;
      end else if (psel && penable) begin
        if (!in_xfer || paddr !== s_addr || pwdata !== s_data || pwrite !== s_write || pstrb !== 4'hF) proto_errs++;
        if (hold_ready && paddr == hold_addr) pready = 1'b0;
        else if (wait_left > 0) begin
          pready = 1'b0;
          wait_left--;
        end else pready = 1'b1;
        if (pready) begin
          in_xfer = 1'b0;
          expect_idle = 1'b1;
          if (pwrite) begin
            wr_addr.push_back(paddr);
            wr_data.push_back(pwdata);
          end else begin
            n_reads++;
            if (paddr !== 16'h0000) proto_errs++;
            prdata = 32'hA5A5_0000 | 32'(never_clear || start_reads > 0);
            if (start_reads > 0) start_reads--;
          end
        end
      end else begin
        if (in_xfer) proto_errs++;
        in_xfer = 1'b0;
        pready = 1'b0;
      end
    end
  end

  function automatic logic [31:0] model_word(input int base, input int len);
    logic [31:0] w = '0;
    for (int i = 0; i < len; i++) w[i*8 +: 8] = elems[base + i];
    return w;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    elem_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    n_reads = 0;
    proto_errs = 0;
  endtask

  task automatic start_cmd(input logic [1:0] n, k, m, sp);
    int b = 0;
    cmd_n = n;
    cmd_k = k;
    cmd_m = m;
    cmd_sp = sp;
    cmd_valid = 1'b1;
    while (!cmd_ready && b < 100) begin
      @(negedge clk);
      b++;
    end
    checks++;
    if (!cmd_ready) begin
      failures++;
      $display("FAIL cmd_accept: cmd_ready=%0b required=1", cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic feed_elems(input int first, input int cnt, input int gap_max);
    int b;
    for (int i = first; i < first + cnt; i++) begin
      elem_valid = 1'b0;
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      elem_valid = 1'b1;
      elem_data = elems[i];
      b = 0;
      while (!elem_ready && b < 300) begin
        @(negedge clk);
        b++;
      end
      checks++;
      if (!elem_ready) begin
        failures++;
        $display("FAIL elem_handshake[%0d]: elem_ready=%0b required=1", i, elem_ready);
        elem_valid = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
    elem_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int b = 0;
    while (done_cnt < target && b < 3000) begin
      @(negedge clk);
      b++;
    end
    checks++;
    if (done_cnt < target) begin
      failures++;
      $display("FAIL %s_done: done_count=%0d required=%0d", name, done_cnt, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks += 8;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); end
    if (psel !== 1'b0) begin failures++; $display("FAIL reset_psel: got %0b want 0", psel); end
    if (penable !== 1'b0) begin failures++; $display("FAIL reset_penable: got %0b want 0", penable); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", busy); end
    if (done !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b/%0b want 0/0", done, timeout); end
    if (elem_ready !== 1'b0) begin failures++; $display("FAIL reset_elem_ready: got %0b want 0", elem_ready); end
    if (paddr !== 16'h0 || pwdata !== 32'h0 || pwrite !== 1'b0) begin failures++; $display("FAIL reset_bus: paddr=%h pwdata=%h pwrite=%0b want 0", paddr, pwdata, pwrite); end
    if (pstrb !== 4'h0) begin failures++; $display("FAIL reset_pstrb: got %h want 0", pstrb); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks += 2;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset: cmd_ready=%0b busy=%0b want 1/0", cmd_ready, busy); end
    if (psel !== 1'b0) begin failures++; $display("FAIL idle_psel: got %0b want 0", psel); end
  endtask

  task automatic load_t1();
    logic [7:0] v[8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd7, 8'd6, 8'd8};
    for (int i = 0; i < 8; i++) elems[i] = v[i];
  endtask

  task automatic test_basic_2x2(input string name);
    int base = done_cnt;
    logic [15:0] a;
    logic [31:0] d;
    load_t1();
    clear_log();
    wait_max = 0;
    start_reads = 0;
    start_cmd(2'd1, 2'd1, 2'd1, 2'd0);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL %s_busy: got %0b want 1", name, busy); end
    feed_elems(0, 8, 0);
    wait_done(base + 1, name);
    checks += 4;
    if (wr_addr.size() != 5) begin failures++; $display("FAIL %s_write_count: got %0d want 5", name, wr_addr.size()); end
    for (int i = 0; i < 5; i++) begin
      a = i < wr_addr.size() ? wr_addr[i] : 16'hxxxx;
      d = i < wr_data.size() ? wr_data[i] : 32'hxxxx_xxxx;
      checks++;
      if (a !== t1_addr[i] || d !== t1_data[i]) begin
        failures++;
        $display("FAIL %s_write[%0d]: got %h=%h want %h=%h", name, i, a, d, t1_addr[i], t1_data[i]);
      end
    end
    if (n_reads != 1) begin failures++; $display("FAIL %s_reads: got %0d want 1", name, n_reads); end
    if (last_to !== 1'b0) begin failures++; $display("FAIL %s_timeout: got %0b want 0", name, last_to); end
    if (proto_errs != 0) begin failures++; $display("FAIL %s_protocol: errors=%0d want 0", name, proto_errs); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL %s_end_state: done=%0b cmd_ready=%0b want 0/1", name, done, cmd_ready); end
  endtask

  task automatic test_full_4x4_waits();
    int base = done_cnt;
    logic [15:0] a, ea;
    logic [31:0] d, ed;
    for (int i = 0; i < 32; i++) elems[i] = 8'(i * 37 + 11);
    clear_log();
    wait_max = 3;
    start_cmd(2'd3, 2'd3, 2'd3, 2'd2);
    feed_elems(0, 32, 0);
    wait_done(base + 1, "full4x4");
    checks += 3;
    if (wr_addr.size() != 9) begin failures++; $display("FAIL full4x4_write_count: got %0d want 9", wr_addr.size()); end
    for (int i = 0; i < 9; i++) begin
      ea = i < 4 ? 16'(i * 32 + 4) : i < 8 ? 16'((i - 4) * 32 + 8) : 16'h0000;
      ed = i < 8 ? model_word(i * 4, 4) : 32'h0000_3F09;
      a = i < wr_addr.size() ? wr_addr[i] : 16'hxxxx;
      d = i < wr_data.size() ? wr_data[i] : 32'hxxxx_xxxx;
      checks++;
      if (a !== ea || d !== ed) begin
        failures++;
        $display("FAIL full4x4_write[%0d]: got %h=%h want %h=%h", i, a, d, ea, ed);
      end
    end
    if (proto_errs != 0) begin failures++; $display("FAIL full4x4_protocol_stable: errors=%0d want 0", proto_errs); end
    if (n_reads != 1) begin failures++; $display("FAIL full4x4_reads: got %0d want 1", n_reads); end
    wait_max = 0;
  endtask

  task automatic test_signed_1x1();
    int base = done_cnt;
    elems[0] = 8'hFD;
    elems[1] = 8'h07;
    clear_log();
    start_cmd(2'd0, 2'd0, 2'd0, 2'd0);
    feed_elems(0, 2, 0);
    wait_done(base + 1, "signed1x1");
    checks += 4;
    if (wr_addr.size() != 3) begin failures++; $display("FAIL signed1x1_write_count: got %0d want 3", wr_addr.size()); end
    if (wr_addr.size() < 3 || wr_addr[0] !== 16'h0004 || wr_data[0] !== 32'h0000_00FD) begin
      failures++; $display("FAIL signed1x1_a: got %h=%h want 0004=000000fd", wr_addr[0], wr_data[0]);
    end
    if (wr_addr.size() < 3 || wr_addr[1] !== 16'h0008 || wr_data[1] !== 32'h0000_0007) begin
      failures++; $display("FAIL signed1x1_b: got %h=%h want 0008=00000007", wr_addr[1], wr_data[1]);
    end
    if (wr_addr.size() < 3 || wr_addr[2] !== 16'h0000 || wr_data[2] !== 32'h0000_0001) begin
      failures++; $display("FAIL signed1x1_ctrl: got %h=%h want 0000=00000001", wr_addr[2], wr_data[2]);
    end
  endtask

  task automatic test_poll();
    int base = done_cnt;
    elems[0] = 8'h11;
    elems[1] = 8'h22;
    clear_log();
    start_reads = 5;
    start_cmd(2'd0, 2'd0, 2'd0, 2'd1);
    feed_elems(0, 2, 0);
    wait_done(base + 1, "poll_clear");
    checks += 2;
    if (n_reads != 6) begin failures++; $display("FAIL poll_clear_reads: got %0d want 6", n_reads); end
    if (last_to !== 1'b0) begin failures++; $display("FAIL poll_clear_timeout: got %0b want 0", last_to); end
    base = done_cnt;
    clear_log();
    never_clear = 1'b1;
    start_cmd(2'd0, 2'd0, 2'd0, 2'd1);
    feed_elems(0, 2, 0);
    wait_done(base + 1, "poll_limit");
    checks += 3;
    if (n_reads != 8) begin failures++; $display("FAIL poll_limit_reads: got %0d want 8", n_reads); end
    if (last_to !== 1'b1) begin failures++; $display("FAIL poll_limit_timeout: got %0b want 1", last_to); end
    if (proto_errs != 0) begin failures++; $display("FAIL poll_protocol: errors=%0d want 0", proto_errs); end
    never_clear = 1'b0;
    start_reads = 0;
  endtask

  task automatic test_reset_mid_job();
    int b = 0;
    load_t1();
    clear_log();
    hold_addr = 16'h0024;
    hold_ready = 1'b1;
    start_cmd(2'd1, 2'd1, 2'd1, 2'd0);
    feed_elems(0, 4, 0);
    while (!(psel && penable && paddr == 16'h0024) && b < 100) begin
      @(negedge clk);
      b++;
    end
    checks++;
    if (!(psel && penable && paddr == 16'h0024)) begin
      failures++; $display("FAIL midjob_access: psel=%0b penable=%0b paddr=%h want 1/1/0024", psel, penable, paddr);
    end
    #2 rst = 1'b1;
    #1;
    checks += 3;
    if (psel !== 1'b0 || penable !== 1'b0) begin failures++; $display("FAIL midjob_psel_drop: psel=%0b penable=%0b want 0/0", psel, penable); end
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL midjob_cmd_ready: got %0b want 1", cmd_ready); end
    if (busy !== 1'b0 || elem_ready !== 1'b0) begin failures++; $display("FAIL midjob_idle: busy=%0b elem_ready=%0b want 0/0", busy, elem_ready); end
    hold_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_basic_2x2("after_reset");
  endtask

  task automatic test_gaps_and_busy_cmd();
    int base = done_cnt;
    logic [15:0] a, ea;
    logic [31:0] d, ed;
    for (int i = 0; i < 12; i++) elems[i] = 8'(8'hF0 - i * 19);
    clear_log();
    start_cmd(2'd1, 2'd2, 2'd1, 2'd3);
    fork
      feed_elems(0, 12, 4);
      begin
        repeat (3) @(negedge clk);
        cmd_n = 2'd0;
        cmd_k = 2'd0;
        cmd_m = 2'd0;
        cmd_valid = 1'b1;
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
      end
    join
    wait_done(base + 1, "gaps");
    repeat (20) @(negedge clk);
    checks += 4;
    if (done_cnt != base + 1) begin failures++; $display("FAIL gaps_done_pulses: got %0d want %0d", done_cnt - base, 1); end
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL gaps_idle: busy=%0b cmd_ready=%0b want 0/1", busy, cmd_ready); end
    if (wr_addr.size() != 5) begin failures++; $display("FAIL gaps_write_count: got %0d want 5", wr_addr.size()); end
    for (int i = 0; i < 5; i++) begin
      ea = i < 2 ? 16'(i * 32 + 4) : i < 4 ? 16'((i - 2) * 32 + 8) : 16'h0000;
      ed = i < 4 ? model_word(i * 3, 3) : 32'h0000_190D;
      a = i < wr_addr.size() ? wr_addr[i] : 16'hxxxx;
      d = i < wr_data.size() ? wr_data[i] : 32'hxxxx_xxxx;
      checks++;
      if (a !== ea || d !== ed) begin
        failures++;
        $display("FAIL gaps_write[%0d]: got %h=%h want %h=%h", i, a, d, ea, ed);
      end
    end
    if (last_to !== 1'b0) begin failures++; $display("FAIL gaps_timeout: got %0b want 0", last_to); end
  endtask

  initial begin
    test_reset();
    test_basic_2x2("basic2x2");
    test_full_4x4_waits();
    test_signed_1x1();
    test_poll();
    test_reset_mid_job();
    test_gaps_and_busy_cmd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
